// File: rtl/bcd_counter_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_counter_ctrl
//
// Keypad-driven sequencer for a chain of one-hot-mode BCD digit counters.
// Single-cycle key events become counter mode commands (preset, clear, count
// up, count down). Digit keys build a multi-digit preset value, entered
// calculator style. A built-in prescaler generates the count-enable pulse for
// the least-significant digit. Each digit's carry/borrow in the external chain
// feeds the next digit's count enable.
//
// Parameters
//   DIGITS    number of BCD digits in the chain (1..8)
//   TICK_DIV  clock cycles per count tick (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   key_valid   one-cycle strobe qualifying key_code
//   key_code    0x0-0x9 digit, 0xA up, 0xB down, 0xC clear, 0xD stop,
//               0xE edit, 0xF load
//   mode        one-hot counter command: 0001 preset, 0010 clear,
//               0100 up, 1000 down, 0000 hold
//   bcd_preset  preset value, digit i at [4i+3:4i], digit 0 least significant
//   bcin        count-enable pulse to digit 0
//   state       current FSM state, for display/debug
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [3:0]            mode,
  output logic [4*DIGITS-1:0]   bcd_preset,
  output logic                  bcin,
  output logic [2:0]            state
);

  // ---------------------------------------------------------------------------
  // Local widths and constants
  // ---------------------------------------------------------------------------
  localparam int BW = 4 * DIGITS;              // preset buffer width
  localparam int CW = $clog2(DIGITS + 1);      // entry count holds 0..DIGITS
  localparam int PW = $clog2(TICK_DIV);        // prescaler holds 0..TICK_DIV-1

  localparam logic [CW-1:0] CNT_FULL  = CW'(DIGITS);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN_UP = 3'd1,
    S_RUN_DN = 3'd2,
    S_EDIT   = 3'd3,
    S_LOAD   = 3'd4,
    S_CLR    = 3'd5
  } state_t;

  // Command keys; codes 0x0-0x9 are digits.
  localparam logic [3:0] K_UP    = 4'hA;
  localparam logic [3:0] K_DOWN  = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;
  localparam logic [3:0] K_STOP  = 4'hD;
  localparam logic [3:0] K_EDIT  = 4'hE;
  localparam logic [3:0] K_LOAD  = 4'hF;

  localparam logic [3:0] MODE_HOLD   = 4'b0000;
  localparam logic [3:0] MODE_PRESET = 4'b0001;
  localparam logic [3:0] MODE_CLEAR  = 4'b0010;
  localparam logic [3:0] MODE_UP     = 4'b0100;
  localparam logic [3:0] MODE_DOWN   = 4'b1000;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [BW-1:0]   buf_q,   buf_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [PW-1:0]   presc_q, presc_d;

  logic            run_q;        // currently in a RUN state
  logic            run_d;        // will be in a RUN state after this edge
  logic            run_restart;  // A/B accepted in a RUN state
  logic            is_digit;

  assign is_digit = (key_code <= 4'd9);
  assign run_q    = (state_q == S_RUN_UP) || (state_q == S_RUN_DN);
  assign run_d    = (state_d == S_RUN_UP) || (state_d == S_RUN_DN);

  // ---------------------------------------------------------------------------
  // Next-state and entry-buffer logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    run_restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          case (key_code)
            K_UP:    state_d = S_RUN_UP;
            K_DOWN:  state_d = S_RUN_DN;
            K_CLEAR: state_d = S_CLR;
            K_EDIT: begin
              state_d = S_EDIT;
              buf_d   = '0;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end

      S_RUN_UP, S_RUN_DN: begin
        if (key_valid) begin
          case (key_code)
            K_STOP:  state_d = S_IDLE;
            // Re-pressing a direction key restarts the tick period even when
            // the direction is unchanged.
            K_UP: begin
              state_d     = S_RUN_UP;
              run_restart = 1'b1;
            end
            K_DOWN: begin
              state_d     = S_RUN_DN;
              run_restart = 1'b1;
            end
            K_CLEAR: state_d = S_CLR;
            K_EDIT: begin
              state_d = S_EDIT;
              buf_d   = '0;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end

      S_EDIT: begin
        if (key_valid) begin
          if (is_digit) begin
            // Calculator-style entry: existing digits move up one place and
            // the new digit lands in digit 0. Once DIGITS digits are held,
            // further digits are dropped so the top digit is never lost.
            if (cnt_q < CNT_FULL) begin
              buf_d = (buf_q << 4) | BW'(key_code);
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            case (key_code)
              K_CLEAR: begin
                buf_d = '0;
                cnt_d = '0;
              end
              K_LOAD:  state_d = S_LOAD;
              // Stop leaves edit with the buffer intact but not loaded.
              K_STOP:  state_d = S_IDLE;
              default: ;
            endcase
          end
        end
      end

      // One-cycle command states; keys arriving here are dropped.
      S_LOAD:  state_d = S_IDLE;
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler: free-runs only in RUN states, restarts on every RUN entry
  // (including a direction key pressed while already running), and sits at
  // zero everywhere else so the first pulse lands in the TICK_DIV-th cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = '0;
    if (run_d && run_q && !run_restart) begin
      presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, so they follow reset immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    mode = MODE_HOLD;
    case (state_q)
      S_RUN_UP: mode = MODE_UP;
      S_RUN_DN: mode = MODE_DOWN;
      S_LOAD:   mode = MODE_PRESET;
      S_CLR:    mode = MODE_CLEAR;
      default:  mode = MODE_HOLD;
    endcase
  end

  // A key accepted while bcin is high still lets this tick through with the
  // old mode; the new state only takes effect after the edge.
  assign bcin       = run_q && (presc_q == TICK_LAST);
  assign bcd_preset = buf_q;
  assign state      = state_q;

endmodule

// File: doc/bcd_counter_ctrl.md
# bcd_counter_ctrl

Keypad-driven sequencer for a chain of one-hot-mode BCD digit counters. It turns single-cycle key events into counter mode commands: preset, clear, count up and count down. It also builds the multi-digit preset value from entered digits. A built-in prescaler generates the count-enable pulse that drives the least-significant digit. The block sits between the key scanner/decoder and the counter chain, where each digit's carry/borrow output feeds the next digit's count enable.

## Interface
- DIGITS, 4: number of BCD digits in the chain; legal range 1..8.
- TICK_DIV, 50_000_000: clock cycles per count tick; minimum 2.

- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle
- key_code  in  4  0x0–0x9 digit; 0xA up; 0xB down; 0xC clear; 0xD stop; 0xE edit; 0xF load
- mode  out  4  one-hot counter command: 0001 preset, 0010 clear, 0100 up, 1000 down, 0000 hold
- bcd_preset  out  4*DIGITS  preset value; digit i is at bits [4i+3:4i], and digit 0 is least significant
- bcin  out  1  count-enable pulse to digit 0
- state  out  3  current FSM state, for display/debug

## Operation
- FSM states and their encodings:
  - IDLE = 0: mode 0000
  - RUN_UP = 1: mode 0100
  - RUN_DN = 2: mode 1000
  - EDIT = 3: mode 0000
  - LOAD = 4: mode 0001
  - CLR = 5: mode 0010
- mode is a pure decode of the registered state.
- IDLE:
  - A → RUN_UP
  - B → RUN_DN
  - C → CLR
  - E → EDIT, clearing the buffer and entry count
  - All other keys are ignored.
- RUN_UP / RUN_DN:
  - D → IDLE
  - A → RUN_UP; B → RUN_DN. Either key restarts the prescaler, even if the direction does not change.
  - C → CLR
  - E → EDIT, clearing the buffer and entry count
  - Digit keys and F are ignored.
- EDIT:
  - Digit key, when entry count < DIGITS: buffer shifts left one digit and the new digit enters digit 0 (calculator style). Entry count increments.
  - Digit key, when entry count = DIGITS: ignored.
  - C: buffer and count are cleared; state stays EDIT.
  - F → LOAD.
  - D → IDLE; the buffer is kept but not loaded.
  - A, B and E are ignored.
- LOAD: lasts exactly one cycle, then → IDLE. Keys arriving in this cycle are ignored.
- CLR: lasts exactly one cycle, then → IDLE. Keys arriving in this cycle are ignored.
- bcd_preset is driven directly from the buffer register at all times.
- Digit values are only ever 0–9 by construction; no BCD correction is needed.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps, only while in RUN_UP or RUN_DN.
  - Held at 0 in every other state.
  - Cleared on every entry into a RUN state.
- bcin = (state is RUN_UP or RUN_DN) AND (prescaler == TICK_DIV-1). It is combinational from registers and never asserted outside the RUN states.

## Timing
- Reset values, applied immediately on rst assertion independent of clk:
  - state = IDLE, mode = 0000, bcin = 0, bcd_preset = 0
  - Entry count = 0, prescaler = 0
- A key sampled at edge k takes effect in state and mode immediately after edge k.
  - Latency from key to command is 1 cycle.
- First bcin after entering a RUN state is in the TICK_DIV-th cycle of that state. After that, one pulse every TICK_DIV cycles, each exactly one cycle wide.
- A key accepted in a cycle where bcin = 1:
  - The counter chain still sees the old mode plus bcin at that edge, so the tick is applied.
  - The new state takes effect after that edge.
- LOAD: mode = 0001 for exactly one cycle. bcd_preset is stable throughout, because it changed no later than the F edge.
- CLR: mode = 0010 for exactly one cycle.
- Reset asserted mid-EDIT or mid-RUN: all partial entry is lost and no further bcin is produced.
- On rst deassertion, the FSM starts in IDLE on the next rising edge.

## Test plan
- Reset: set rst = 1 during RUN_UP with the prescaler mid-count → same cycle shows mode 0000, bcin 0, state 0, bcd_preset 0. After release, no bcin for 20 cycles.
- Run up (TICK_DIV = 4): key A → mode 0100 from the next cycle. bcin is high in state cycles 4, 8, 12, 16, 20, giving exactly 5 pulses in 20 cycles. Then key D → mode 0000 and bcin stays 0.
- Edit overflow (DIGITS = 4): keys E,1,2,3,4,5,F → bcd_preset = 0x1234 (the 5 is ignored). mode = 0001 for exactly one cycle, then 0000 and state IDLE.
- Short entry and clear-in-edit: keys E,9,C,7,F → bcd_preset = 0x0007 and one preset cycle.
- Clear from down-run: key B, then C after 6 cycles (TICK_DIV = 4) → exactly one bcin pulse before C, mode 1000 → 0010 (one cycle) → 0000.
- Simultaneous events: key D in the same cycle as a bcin pulse → bcin = 1 in that cycle and mode 0000 in the next. Key B while in RUN_DN → the prescaler restarts, and the next bcin comes 4 cycles later.
